// File: rtl/video_mixer_gen.sv
// video_mixer_gen: parametrised RGB output mixer between core video and the
// HDMI/VGA output stage, one instance per video path.
//
// Ports:
//   CLK_VIDEO            video clock, single domain
//   RESET_N              synchronous active-low reset
//   ce_pix               pixel clock-enable (or pixel clock at CLK_VIDEO rate)
//   R, G, B [CW-1:0]     input colour
//   HSync, VSync         positive sync pulses
//   HBlank, VBlank       positive blanking
//   FREEZE               asynchronous freeze request, applied at frame start
//   SL_MODE [1:0]        scanline dim: 0 off, 1 25%, 2 50%, 3 75%
//   CE_PIXEL             registered output pixel enable
//   VGA_R/G/B [7:0]      output colour
//   VGA_HS/VS/DE         output syncs and data enable
//
// Parameters: CW (1..8) input bits per channel, SL_EN (1 = scanlines present).
// Build option: define VIDEO_MIXER_GEN_BLANK_EN to zero colour during blanking.

module video_mixer_gen #(
    parameter int CW    = 8,
    parameter int SL_EN = 1
) (
    input  logic          CLK_VIDEO,
    input  logic          RESET_N,
    input  logic          ce_pix,
    input  logic [CW-1:0] R,
    input  logic [CW-1:0] G,
    input  logic [CW-1:0] B,
    input  logic          HSync,
    input  logic          VSync,
    input  logic          HBlank,
    input  logic          VBlank,
    input  logic          FREEZE,
    input  logic [1:0]    SL_MODE,
    output logic          CE_PIXEL,
    output logic [7:0]    VGA_R,
    output logic [7:0]    VGA_G,
    output logic [7:0]    VGA_B,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_DE
);

    // Bit replication: output bit 7-i takes input bit CW-1-(i mod CW),
    // so the CW-bit pattern repeats MSB-first and is truncated to 8 bits.
    logic [7:0] r_x, g_x, b_x;

    for (genvar i = 0; i < 8; i++) begin : g_exp
        assign r_x[7-i] = R[CW-1-(i%CW)];
        assign g_x[7-i] = G[CW-1-(i%CW)];
        assign b_x[7-i] = B[CW-1-(i%CW)];
    end

    // Stage-1 registers
    logic [7:0] r1, g1, b1;
    logic       hde, vde, hs, vs;

    // Edge history and frame state
    logic       old_vs, old_hs, old_ce, old_hde;
    logic       fs_osc, ce_osc, parity;
    logic       frz_m, frz_s, frz;
    logic [1:0] sl_mode;

    logic vs_rise, hs_rise, sl_on;

    assign vs_rise = vs & ~old_vs;
    assign hs_rise = hs & ~old_hs;
    assign sl_on   = (SL_EN != 0) && parity;

    function automatic logic [7:0] dim(input logic [7:0] c,
                                       input logic [1:0] m);
        logic [7:0] d;
        case (m)
            2'd1:    d = c - (c >> 2);
            2'd2:    d = c >> 1;
            2'd3:    d = c >> 2;
            default: d = c;
        endcase
        return d;
    endfunction

    logic [7:0] r_o, g_o, b_o;

    always_comb begin
        r_o = frz ? 8'd0 : r1;
        g_o = frz ? 8'd0 : g1;
        b_o = frz ? 8'd0 : b1;
        if (sl_on) begin
            r_o = dim(r_o, sl_mode);
            g_o = dim(g_o, sl_mode);
            b_o = dim(b_o, sl_mode);
        end
`ifdef VIDEO_MIXER_GEN_BLANK_EN
        if (!(vde & hde)) begin
            r_o = 8'd0;
            g_o = 8'd0;
            b_o = 8'd0;
        end
`endif
    end

    // Input stage and frame-aligned control state
    always_ff @(posedge CLK_VIDEO) begin
        if (!RESET_N) begin
            r1       <= 8'd0;
            g1       <= 8'd0;
            b1       <= 8'd0;
            hde      <= 1'b0;
            vde      <= 1'b0;
            hs       <= 1'b0;
            vs       <= 1'b0;
            old_vs   <= 1'b0;
            old_hs   <= 1'b0;
            old_ce   <= 1'b0;
            fs_osc   <= 1'b0;
            ce_osc   <= 1'b0;
            parity   <= 1'b0;
            frz_m    <= 1'b0;
            frz_s    <= 1'b0;
            frz      <= 1'b0;
            sl_mode  <= 2'd0;
            CE_PIXEL <= 1'b0;
        end else begin
            r1     <= r_x;
            g1     <= g_x;
            b1     <= b_x;
            hde    <= ~HBlank;
            vde    <= ~VBlank;
            hs     <= HSync;
            vs     <= VSync;
            old_vs <= vs;
            old_hs <= hs;
            old_ce <= ce_pix;
            frz_m  <= FREEZE;
            frz_s  <= frz_m;

            // fs_osc set: ce_pix toggled last frame, so it is a clock and
            // only its rising edges count; otherwise it is used as a level.
            CE_PIXEL <= fs_osc ? (~old_ce & ce_pix) : ce_pix;

            if (vs_rise) begin
                fs_osc  <= ce_osc;
                ce_osc  <= 1'b0;
                frz     <= frz_s;
                sl_mode <= SL_MODE;
                parity  <= 1'b0;
            end else begin
                if (ce_pix != old_ce) ce_osc <= 1'b1;
                if (hs_rise) parity <= ~parity;
            end
        end
    end

    // Output stage, advanced only on CE_PIXEL
    always_ff @(posedge CLK_VIDEO) begin
        if (!RESET_N) begin
            VGA_R   <= 8'd0;
            VGA_G   <= 8'd0;
            VGA_B   <= 8'd0;
            VGA_HS  <= 1'b0;
            VGA_VS  <= 1'b0;
            VGA_DE  <= 1'b0;
            old_hde <= 1'b0;
        end else if (CE_PIXEL) begin
            VGA_R   <= r_o;
            VGA_G   <= g_o;
            VGA_B   <= b_o;
            VGA_HS  <= hs;
            VGA_VS  <= vs;
            old_hde <= hde;
            // DE only moves at horizontal blank boundaries
            if (old_hde != hde) VGA_DE <= vde & hde;
        end
    end

endmodule

// File: tb/tb_video_mixer_gen.sv
// tb_video_mixer_gen: directed bench for video_mixer_gen.
// Three instances (CW=8, 4, 3) share stimulus; checks via immediate asserts.

module tb_video_mixer_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ce_pix;
    logic [7:0] R, G, B;
    logic       HSync, VSync, HBlank, VBlank, FREEZE;
    logic [1:0] SL_MODE;

    logic       ce8, hs8, vs8, de8;
    logic [7:0] r8, g8, b8;
    logic       ce4, hs4, vs4, de4;
    logic [7:0] r4, g4, b4;
    logic       ce3, hs3, vs3, de3;
    logic [7:0] r3, g3, b3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    video_mixer_gen #(.CW(8), .SL_EN(1)) dut (
        .CLK_VIDEO(clk), .RESET_N(rst_n), .ce_pix(ce_pix),
        .R(R), .G(G), .B(B),
        .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
        .FREEZE(FREEZE), .SL_MODE(SL_MODE), .CE_PIXEL(ce8),
        .VGA_R(r8), .VGA_G(g8), .VGA_B(b8),
        .VGA_HS(hs8), .VGA_VS(vs8), .VGA_DE(de8)
    );

    video_mixer_gen #(.CW(4), .SL_EN(1)) dut4 (
        .CLK_VIDEO(clk), .RESET_N(rst_n), .ce_pix(ce_pix),
        .R(R[7:4]), .G(G[7:4]), .B(B[7:4]),
        .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
        .FREEZE(FREEZE), .SL_MODE(SL_MODE), .CE_PIXEL(ce4),
        .VGA_R(r4), .VGA_G(g4), .VGA_B(b4),
        .VGA_HS(hs4), .VGA_VS(vs4), .VGA_DE(de4)
    );

    video_mixer_gen #(.CW(3), .SL_EN(1)) dut3 (
        .CLK_VIDEO(clk), .RESET_N(rst_n), .ce_pix(ce_pix),
        .R(R[7:5]), .G(G[7:5]), .B(B[7:5]),
        .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
        .FREEZE(FREEZE), .SL_MODE(SL_MODE), .CE_PIXEL(ce3),
        .VGA_R(r3), .VGA_G(g3), .VGA_B(b3),
        .VGA_HS(hs3), .VGA_VS(vs3), .VGA_DE(de3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Frame events land on the second edge (stage-1 rise detect)
    task automatic vs_pulse();
        VSync = 1'b1;
        tick();
        VSync = 1'b0;
        tick();
    endtask

    task automatic hs_pulse();
        HSync = 1'b1;
        tick();
        HSync = 1'b0;
        tick();
    endtask

    initial begin
        rst_n   = 1'b0;
        ce_pix  = 1'b0;
        R       = 8'h00;
        G       = 8'h00;
        B       = 8'h00;
        HSync   = 1'b0;
        VSync   = 1'b0;
        HBlank  = 1'b0;
        VBlank  = 1'b0;
        FREEZE  = 1'b0;
        SL_MODE = 2'd0;
        ticks(2);

        chk("rst_ce", ce8, 8'h00);
        chk("rst_r", r8, 8'h00);
        chk("rst_de", de8, 8'h00);
        chk("rst_hs", hs8, 8'h00);
        chk("rst_vs", vs8, 8'h00);

        // First frame: CE_PIXEL follows the ce_pix level
        rst_n = 1'b1;
        tick();
        chk("lvl_0", ce8, 8'h00);
        ce_pix = 1'b1;
        tick();
        chk("lvl_rise", ce8, 8'h01);
        tick();
        chk("lvl_hold", ce8, 8'h01);
        ce_pix = 1'b0;
        tick();
        chk("lvl_fall", ce8, 8'h00);
        vs_pulse();

        // Next frame: ce_pix toggled, so only rising edges pulse
        ce_pix = 1'b1;
        tick();
        chk("osc_rise", ce8, 8'h01);
        tick();
        chk("osc_hold", ce8, 8'h00);
        vs_pulse();
        tick();
        chk("osc_steady", ce8, 8'h00);
        vs_pulse();
        tick();
        chk("lvl_again", ce8, 8'h01);

        // Expansion and two-edge latency
        R = 8'hA0;
        G = 8'hFF;
        B = 8'h10;
        tick();
        chk("lat_early", r4, 8'h00);
        tick();
        chk("cw4_r", r4, 8'hAA);
        chk("cw4_g", g4, 8'hFF);
        chk("cw4_b", b4, 8'h11);
        chk("cw3_r", r3, 8'hB6);
        chk("cw3_b", b3, 8'h00);
        chk("cw8_r", r8, 8'hA0);
        chk("cw4_ce", ce4, 8'h01);

        // DE at horizontal blank boundaries
        chk("de_on", de8, 8'h01);
        HBlank = 1'b1;
        ticks(2);
        chk("de_hblank", de8, 8'h00);
        chk("blank_rgb", r8, 8'hA0);
        VBlank = 1'b1;
        ticks(2);
        HBlank = 1'b0;
        ticks(2);
        chk("de_vblank", de8, 8'h00);
        VBlank = 1'b0;
        ticks(2);
        chk("de_vmid", de8, 8'h00);
        HBlank = 1'b1;
        ticks(2);
        HBlank = 1'b0;
        tick();
        chk("de_pre", de8, 8'h00);
        tick();
        chk("de_edge", de8, 8'h01);
        VBlank = 1'b1;
        ticks(2);
        chk("de_vmid1", de8, 8'h01);
        VBlank = 1'b0;
        ticks(2);

        // Scanlines
        R = 8'hC8;
        SL_MODE = 2'd2;
        hs_pulse();
        tick();
        chk("sl_pend", r8, 8'hC8);
        vs_pulse();
        tick();
        chk("sl2_even", r8, 8'hC8);
        hs_pulse();
        tick();
        chk("sl2_odd", r8, 8'h64);
        hs_pulse();
        tick();
        chk("sl2_even2", r8, 8'hC8);
        SL_MODE = 2'd1;
        vs_pulse();
        hs_pulse();
        tick();
        chk("sl1_odd", r8, 8'h96);
        SL_MODE = 2'd3;
        vs_pulse();
        hs_pulse();
        tick();
        chk("sl3_odd", r8, 8'h32);
        // Coincident hs/vs rises: parity clears rather than toggles
        HSync = 1'b1;
        VSync = 1'b1;
        tick();
        HSync = 1'b0;
        VSync = 1'b0;
        tick();
        HSync = 1'b1;
        VSync = 1'b1;
        tick();
        HSync = 1'b0;
        VSync = 1'b0;
        tick();
        tick();
        chk("sl_hsvs", r8, 8'hC8);
        SL_MODE = 2'd0;
        vs_pulse();

        // Freeze
        FREEZE = 1'b1;
        ticks(3);
        chk("frz_pend", r8, 8'hC8);
        vs_pulse();
        tick();
        chk("frz_r", r8, 8'h00);
        chk("frz_g", g8, 8'h00);
        HSync = 1'b1;
        ticks(2);
        chk("frz_hs1", hs8, 8'h01);
        HSync = 1'b0;
        ticks(2);
        chk("frz_hs0", hs8, 8'h00);
        HBlank = 1'b1;
        ticks(2);
        chk("frz_de0", de8, 8'h00);
        HBlank = 1'b0;
        ticks(2);
        chk("frz_de1", de8, 8'h01);
        FREEZE = 1'b0;
        ticks(3);
        chk("frz_hold", r8, 8'h00);
        vs_pulse();
        tick();
        chk("frz_rel", r8, 8'hC8);

        // Reset mid-frame clears latched freeze and SL mode
        FREEZE = 1'b1;
        SL_MODE = 2'd2;
        ticks(2);
        vs_pulse();
        tick();
        chk("pre_rst", r8, 8'h00);
        rst_n = 1'b0;
        tick();
        chk("mrst_r", r8, 8'h00);
        chk("mrst_g", g8, 8'h00);
        chk("mrst_ce", ce8, 8'h00);
        chk("mrst_de", de8, 8'h00);
        rst_n = 1'b1;
        ticks(2);
        chk("post_ce", ce8, 8'h01);
        chk("post_r", r8, 8'hC8);
        chk("post_de", de8, 8'h01);
        hs_pulse();
        tick();
        chk("post_sl", r8, 8'hC8);
        FREEZE = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
